operand_fetch: RTL and testbench

- Read-side sequencer for the core's single-read-port register file.
- Accepts a decoded source-operand request (rs1, optional rs2), drives the register file's read address over successive cycles, and captures the combinational read data.
- Returns both operands with a valid/ready handshake.
- Snoops the register file write port, so same-cycle and in-flight writes are bypassed. Register x0 always reads as zero.

---
 rtl/operand_fetch.sv | 109 ++++++++++
 tb/tb_operand_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Read-side sequencer for a single-read-port register file: fetches rs1/rs2 over
// successive cycles, bypasses and snoops write-back, and presents both operands.
//   state | meaning
//   IDLE  | waiting for a request
//   READ1 | rf addressed with rs1, op_a captured
//   READ2 | rf addressed with rs2, op_b captured
//   DONE  | operands valid until out_ready
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_use_rs2,
  output logic [AW-1:0]   rf_read_addr,
  input  logic [XLEN-1:0] rf_data_out,
  input  logic            wb_enable,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b
);

  typedef enum logic [1:0] {IDLE, READ1, READ2, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   rs1_q, rs2_q;
  logic            use_rs2_q;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hit_rs1, hit_rs2;

  // A write landing at this edge is not yet visible on rf_data_out, so forward it.
  assign hit_rs1 = wb_enable && (wb_addr == rs1_q) && (rs1_q != '0);
  assign hit_rs2 = wb_enable && (wb_addr == rs2_q) && (rs2_q != '0);
  assign rs1_val = (rs1_q == '0) ? '0 : (hit_rs1 ? wb_data : rf_data_out);
  assign rs2_val = (rs2_q == '0) ? '0 : (hit_rs2 ? wb_data : rf_data_out);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = READ1;
      READ1:   state_nxt = use_rs2_q ? READ2 : DONE;
      READ2:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    rf_read_addr = '0;
    case (state)
      IDLE:    in_ready = !rst;
      READ1:   rf_read_addr = rs1_q;
      READ2:   rf_read_addr = rs2_q;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs2_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      use_rs2_q <= in_use_rs2;
    end
  end

  // Captured operands keep tracking later writes to their source registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      case (state)
        READ1: begin
          op_a <= rs1_val;
          if (!use_rs2_q) op_b <= '0;
        end
        READ2: begin
          op_b <= rs2_val;
          if (hit_rs1) op_a <= wb_data;
        end
        DONE: begin
          if (hit_rs1) op_a <= wb_data;
          if (use_rs2_q && hit_rs2) op_b <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file attached.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1, in_rs2;
  logic            in_use_rs2;
  logic [AW-1:0]   rf_read_addr;
  logic [XLEN-1:0] rf_data_out;
  logic            wb_enable;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op_a, op_b;

  logic [XLEN-1:0] rf [32] = '{default: '0};

  int checks = 0;
  int errors = 0;

  operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs2(in_use_rs2),
    .rf_read_addr(rf_read_addr), .rf_data_out(rf_data_out),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b)
  );

  always #5 clk = ~clk;

  assign rf_data_out = rf[rf_read_addr];
  always @(posedge clk) if (wb_enable && wb_addr != '0) rf[wb_addr] <= wb_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_enable = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_enable = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u);
    in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_use_rs2 = u;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_use_rs2 = 1'b0;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_rd_addr", rf_read_addr, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    wr(3, 32'h11); wr(7, 32'h22); wr(4, 32'hAA); wr(5, 32'h55);

    // two-operand fetch
    out_ready = 1'b1;
    req(3, 7, 1);
    chk("a_read1_addr", rf_read_addr, 3);
    chk("a_read1_in_ready", in_ready, 0);
    step();
    chk("a_read2_addr", rf_read_addr, 7);
    chk("a_read2_op_a", op_a, 32'h11);
    chk("a_read2_out_valid", out_valid, 0);
    step();
    chk("a_done_out_valid", out_valid, 1);
    chk("a_done_op_a", op_a, 32'h11);
    chk("a_done_op_b", op_b, 32'h22);
    step();
    chk("a_idle_in_ready", in_ready, 1);
    chk("a_idle_out_valid", out_valid, 0);

    // rs1 = x0, rs2 not used: op_b forced to zero, no READ2 cycle
    req(0, 5, 0);
    chk("b_read1_addr", rf_read_addr, 0);
    step();
    chk("b_done_out_valid", out_valid, 1);
    chk("b_done_op_a", op_a, 0);
    chk("b_done_op_b", op_b, 0);
    step();
    chk("b_idle_in_ready", in_ready, 1);

    // same-cycle write bypass during READ1
    req(4, 0, 0);
    chk("c_read1_addr", rf_read_addr, 4);
    wr(4, 32'hBB);
    chk("c_bypass_op_a", op_a, 32'hBB);
    chk("c_out_valid", out_valid, 1);
    step();

    // write to x0 never bypassed
    req(0, 0, 0);
    wr(0, 32'hCC);
    chk("d_x0_op_a", op_a, 0);
    step();

    // snoops while waiting in READ2 and DONE with out_ready low
    out_ready = 1'b0;
    req(3, 7, 1);
    step();
    wr(3, 32'h33);
    chk("e_snoop_read2_op_a", op_a, 32'h33);
    chk("e_done_op_b", op_b, 32'h22);
    wr(7, 32'h99);
    chk("e_snoop_done_op_b", op_b, 32'h99);
    chk("e_snoop_done_op_a", op_a, 32'h33);
    chk("e_hold_out_valid", out_valid, 1);
    step();
    chk("e_hold2_out_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("e_release_in_ready", in_ready, 1);
    chk("e_release_out_valid", out_valid, 0);

    // rs1 == rs2
    req(5, 5, 1);
    step(); step();
    chk("f_same_op_a", op_a, 32'h55);
    chk("f_same_op_b", op_b, 32'h55);
    step();

    // reset during READ2
    req(3, 7, 1);
    step();
    chk("g_in_read2_addr", rf_read_addr, 7);
    rst = 1'b1;
    step();
    chk("g_rst_out_valid", out_valid, 0);
    chk("g_rst_op_a", op_a, 0);
    chk("g_rst_op_b", op_b, 0);
    rst = 1'b0; #1;
    chk("g_rst_in_ready", in_ready, 1);
    chk("g_rst_rd_addr", rf_read_addr, 0);
    req(3, 4, 1);
    step(); step();
    chk("g_after_out_valid", out_valid, 1);
    chk("g_after_op_a", op_a, 32'h33);
    chk("g_after_op_b", op_b, 32'hBB);
    step();
    chk("g_after_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
